// File: rtl/md_unit_iter_pkg.sv
// Shared types for the iterative multiply/divide unit.
// Op encodings, FSM states and op-class helpers.
package md_unit_iter_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MADD  = 4'd5,
    OP_MADDU = 4'd6,
    OP_MSUB  = 4'd7,
    OP_MSUBU = 4'd8,
    OP_MTHI  = 4'd9,
    OP_MTLO  = 4'd10
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } md_state_e;

  // Context captured at acceptance and consumed at FIX
  typedef struct packed {
    logic neg_q;
    logic neg_r;
    logic b_zero;
    logic div;
    logic acc;
    logic sub;
  } md_ctx_t;

  function automatic logic is_mul(md_op_e op);
    return op inside {OP_MULT, OP_MULTU, OP_MADD,
                      OP_MADDU, OP_MSUB, OP_MSUBU};
  endfunction

  function automatic logic is_div(md_op_e op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

  function automatic logic is_signed(md_op_e op);
    return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
  endfunction

  function automatic logic is_acc(md_op_e op);
    return op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  endfunction

  function automatic logic is_sub(md_op_e op);
    return op inside {OP_MSUB, OP_MSUBU};
  endfunction

endpackage

// File: rtl/md_unit_iter_if.sv
// E-stage to multiply/divide unit request and HI/LO read bundle.
// master = pipeline side, slave = md_unit_iter.
interface md_unit_iter_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic [3:0]       md_op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             int_req;
  logic             rollback;
  logic             rd_hi;
  logic [WIDTH-1:0] hilo_rd;
  logic             busy;
  logic             done;

  modport master (
    output start, md_op, src_a, src_b,
    output int_req, rollback, rd_hi,
    input  hilo_rd, busy, done
  );

  modport slave (
    input  start, md_op, src_a, src_b,
    input  int_req, rollback, rd_hi,
    output hilo_rd, busy, done
  );

endinterface

// File: rtl/md_unit_iter_div.sv
// Restoring divider datapath for unsigned magnitudes.
// One quotient bit per enabled cycle, MSB first.
module md_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] d_r;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   diff;

  // Shifted partial remainder never exceeds 2*divisor-1
  assign r_sh = {r_r, q_r[WIDTH-1]};
  assign diff = r_sh - {1'b0, d_r};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_r <= '0;
      r_r <= '0;
      d_r <= '0;
    end else if (load) begin
      q_r <= dividend;
      r_r <= '0;
      d_r <= divisor;
    end else if (en) begin
      if (!diff[WIDTH]) begin
        r_r <= diff[WIDTH-1:0];
        q_r <= {q_r[WIDTH-2:0], 1'b1};
      end else begin
        r_r <= r_sh[WIDTH-1:0];
        q_r <= {q_r[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign quo = q_r;
  assign rem = r_r;

endmodule

// File: rtl/md_unit_iter.sv
// Iterative multiply/divide unit owning HI/LO, with
// accumulate ops and rollback to a one-edge-old snapshot.
module md_unit_iter
  import md_unit_iter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_BPC = 4
) (
  input  logic         clk,
  input  logic         reset,
  md_unit_iter_if.slave md
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] MUL_LAST =
    CW'(WIDTH / MUL_BPC - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

  md_state_e state, state_nx;
  md_op_e    op;
  md_ctx_t   ctx;

  logic [WIDTH-1:0]   hi, lo, hi_save, lo_save;
  logic [WIDTH-1:0]   b_sh, abs_a, abs_b;
  logic [WIDTH-1:0]   quo, rem, lo_div, hi_div;
  logic [2*WIDTH-1:0] a_sh, prod, part;
  logic [2*WIDTH-1:0] p_fix, hilo, mul_res;
  logic [CW-1:0]      cnt;
  logic sa, sb, accept, go_mul, go_div;
  logic mt_hi, mt_lo, done_q;

  assign op     = md_op_e'(md.md_op);
  assign accept = md.start & ~md.int_req &
                  ~md.rollback & (state == S_IDLE);
  assign go_mul = accept & is_mul(op);
  assign go_div = accept & is_div(op);
  assign mt_hi  = accept & (op == OP_MTHI);
  assign mt_lo  = accept & (op == OP_MTLO);

  assign sa    = is_signed(op) & md.src_a[WIDTH-1];
  assign sb    = is_signed(op) & md.src_b[WIDTH-1];
  assign abs_a = sa ? -md.src_a : md.src_a;
  assign abs_b = sb ? -md.src_b : md.src_b;

  // Partial product of the low multiplier digit
  assign part = a_sh *
    {{(2*WIDTH-MUL_BPC){1'b0}}, b_sh[MUL_BPC-1:0]};

  assign hilo    = {hi, lo};
  assign p_fix   = ctx.neg_q ? -prod : prod;
  assign mul_res = !ctx.acc ? p_fix :
                   ctx.sub  ? hilo - p_fix :
                              hilo + p_fix;
  assign lo_div  = ctx.neg_q ? -quo : quo;
  assign hi_div  = ctx.neg_r ? -rem : rem;

  md_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .reset    (reset),
    .load     (go_div),
    .en       (state == S_DIV),
    .dividend (abs_a),
    .divisor  (abs_b),
    .quo      (quo),
    .rem      (rem)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (md.rollback) begin
      state_nx = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (go_mul)      state_nx = S_MUL;
          else if (go_div) state_nx = S_DIV;
        end
        S_MUL: if (cnt == MUL_LAST) state_nx = S_FIX;
        S_DIV: if (cnt == DIV_LAST) state_nx = S_FIX;
        S_FIX: state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi      <= '0;
      lo      <= '0;
      hi_save <= '0;
      lo_save <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      prod    <= '0;
      cnt     <= '0;
      ctx     <= '0;
      done_q  <= 1'b0;
    end else begin
      hi_save <= hi;
      lo_save <= lo;
      done_q  <= 1'b0;
      if (md.rollback) begin
        hi <= hi_save;
        lo <= lo_save;
      end else begin
        if (mt_hi) hi <= md.src_a;
        if (mt_lo) lo <= md.src_a;
        if (go_mul | go_div) begin
          a_sh       <= {{WIDTH{1'b0}}, abs_a};
          b_sh       <= abs_b;
          prod       <= '0;
          cnt        <= '0;
          ctx.neg_q  <= sa ^ sb;
          ctx.neg_r  <= sa;
          ctx.b_zero <= (md.src_b == '0);
          ctx.div    <= go_div;
          ctx.acc    <= is_acc(op);
          ctx.sub    <= is_sub(op);
        end
        unique case (state)
          S_MUL: begin
            prod <= prod + part;
            a_sh <= a_sh << MUL_BPC;
            b_sh <= b_sh >> MUL_BPC;
            cnt  <= cnt + 1'b1;
          end
          S_DIV: cnt <= cnt + 1'b1;
          S_FIX: begin
            cnt    <= '0;
            done_q <= 1'b1;
            if (!ctx.div) begin
              {hi, lo} <= mul_res;
            end else if (!ctx.b_zero) begin
              hi <= hi_div;
              lo <= lo_div;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign md.hilo_rd = md.rd_hi ? hi : lo;
  assign md.busy    = (state != S_IDLE);
  assign md.done    = done_q;

endmodule

// File: tb/tb_md_unit_iter.sv
// Directed and randomized checks of md_unit_iter
// against a plain-arithmetic HI/LO reference model.
module tb_md_unit_iter;
  import md_unit_iter_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  md_unit_iter_if #(.WIDTH(W)) bus ();

  md_unit_iter #(.WIDTH(W), .MUL_BPC(4)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  always @(posedge clk) begin
    assert (!(reset && bus.start === 1'b1 && bus.busy === 1'b1))
    else begin
      errors++;
      $error("FAIL start-while-busy: observed start=1 busy=1");
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(output logic [W-1:0] h,
                    output logic [W-1:0] l);
    bus.rd_hi = 1'b1;
    #1 h = bus.hilo_rd;
    bus.rd_hi = 1'b0;
    #1 l = bus.hilo_rd;
  endtask

  task automatic chk_hilo(input string tag,
                          input logic [W-1:0] eh,
                          input logic [W-1:0] el);
    logic [W-1:0] h, l;
    rd(h, l);
    chk({tag, " hi"}, 64'(h), 64'(eh));
    chk({tag, " lo"}, 64'(l), 64'(el));
  endtask

  function automatic logic [63:0] ref_op(input md_op_e op,
      input logic [W-1:0] a, input logic [W-1:0] b,
      input logic [W-1:0] hi, input logic [W-1:0] lo);
    logic [63:0] acc, p;
    longint sa, sb, q, r;
    acc = {hi, lo};
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    if (op inside {OP_MULT, OP_MADD, OP_MSUB})
      p = 64'(sa * sb);
    else
      p = {32'b0, a} * {32'b0, b};
    case (op)
      OP_MULT, OP_MULTU: return p;
      OP_MADD, OP_MADDU: return acc + p;
      OP_MSUB, OP_MSUBU: return acc - p;
      OP_DIV: begin
        if (b == '0) return acc;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      OP_DIVU: begin
        if (b == '0) return acc;
        return {a % b, a / b};
      end
      default: return acc;
    endcase
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input md_op_e op,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.md_op = op;
    bus.src_a = a;
    bus.src_b = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_op(input md_op_e op,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input string tag);
    logic [63:0] exp;
    int n, lat;
    exp = ref_op(op, a, b, m_hi, m_lo);
    lat = (op inside {OP_DIV, OP_DIVU}) ? W + 1 : W / 4 + 1;
    issue(op, a, b);
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk({tag, " busy-len"}, 64'(n), 64'(lat));
    chk({tag, " done"}, 64'(bus.done), 64'd1);
    chk_hilo(tag, exp[63:32], exp[31:0]);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    @(negedge clk);
    chk({tag, " done-pulse"}, 64'(bus.done), 64'd0);
  endtask

  task automatic mt(input md_op_e op,
                    input logic [W-1:0] a,
                    input string tag);
    issue(op, a, '0);
    chk({tag, " busy"}, 64'(bus.busy), 64'd0);
    if (op == OP_MTHI) m_hi = a;
    else               m_lo = a;
    chk_hilo(tag, m_hi, m_lo);
  endtask

  initial begin
    int seen;
    md_op_e rop;
    bus.start    = 1'b0;
    bus.md_op    = '0;
    bus.src_a    = '0;
    bus.src_b    = '0;
    bus.int_req  = 1'b0;
    bus.rollback = 1'b0;
    bus.rd_hi    = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk_hilo("reset", '0, '0);
    reset = 1'b1;

    run_op(OP_MULT, 32'hFFFF_FFFF, 32'h2, "mult");
    chk("mult const", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu");
    chk("multu const", {m_hi, m_lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(OP_DIVU, 32'd7, 32'd2, "divu");
    chk("divu const", {m_hi, m_lo}, 64'h0000_0001_0000_0003);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div neg");
    chk("div neg const", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div min");
    chk("div min const", {m_hi, m_lo}, 64'h0000_0000_8000_0000);

    mt(OP_MTHI, 32'h0, "mthi");
    mt(OP_MTLO, 32'h5, "mtlo");
    run_op(OP_MADD, 32'd3, 32'd4, "madd");
    chk("madd const", {m_hi, m_lo}, 64'h11);
    run_op(OP_MSUB, 32'd3, 32'd4, "msub");
    chk("msub const", {m_hi, m_lo}, 64'h5);
    run_op(OP_DIV, 32'd9, 32'd0, "div0");
    chk("div0 const", {m_hi, m_lo}, 64'h5);

    mt(OP_MTLO, 32'h1234, "mtlo rb");
    issue(OP_MULT, 32'd7, 32'd9);
    repeat (3) @(negedge clk);
    bus.rollback = 1'b1;
    @(negedge clk);
    bus.rollback = 1'b0;
    chk("rollback busy", 64'(bus.busy), 64'd0);
    chk("rollback done", 64'(bus.done), 64'd0);
    chk_hilo("rollback", m_hi, 32'h1234);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen++;
    end
    chk("rollback no-done", 64'(seen), 64'd0);

    @(negedge clk);
    bus.start   = 1'b1;
    bus.int_req = 1'b1;
    bus.md_op   = OP_MTLO;
    bus.src_a   = 32'h99;
    @(negedge clk);
    bus.md_op   = OP_MULT;
    bus.src_a   = 32'd3;
    bus.src_b   = 32'd3;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.int_req = 1'b0;
    chk("int_req busy", 64'(bus.busy), 64'd0);
    chk_hilo("int_req", m_hi, m_lo);

    issue(OP_DIV, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("areset busy", 64'(bus.busy), 64'd0);
    chk("areset done", 64'(bus.done), 64'd0);
    chk_hilo("areset", '0, '0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    run_op(OP_MULT, 32'd3, 32'd5, "post-reset mult");
    chk("post-reset const", {m_hi, m_lo}, 64'hF);

    for (int i = 0; i < 24; i++) begin
      rop = md_op_e'(4'($urandom_range(1, 8)));
      run_op(rop, pick(), pick(), $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
